dram_dir_bridge: RTL and testbench
==================================

# dram_dir_bridge

AXI4-Lite-style master between the Program core and the pseudo-DRAM. It turns single-entry read and write requests for a `Data_Dir` record (selected by `Data_No`) into address/data channel handshakes. It packs and unpacks the 64-bit DRAM word to and from the 57-bit `Data_Dir` layout. It sits directly downstream of the core's action FSM: `Index_Check` and `Check_Valid_Date` issue reads, and `Update` issues a read followed by a write-back.

## Interface
Parameters:
- `BASE_ADDR`, default 17'h10000: byte address of entry 0.
- `ADDR_W`, default 17: DRAM address width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: bridge idle and able to accept a request.
- `req_write` in 1: 0 = read, 1 = write.
- `req_no` in 8: `Data_No` entry index (0..255).
- `req_wdata` in 57: `Data_Dir` {Index_A, Index_B, Index_C, Index_D, M, D} to write.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 57: unpacked `Data_Dir`; valid on `rsp_valid` of a read, held otherwise.
- `rsp_err` out 1: nonzero RRESP/BRESP on this transaction; qualified by `rsp_valid`.
- `ar_valid` out 1; `ar_addr` out ADDR_W; `ar_ready` in 1.
- `r_valid` in 1; `r_data` in 64; `r_resp` in 2; `r_ready` out 1.
- `aw_valid` out 1; `aw_addr` out ADDR_W; `aw_ready` in 1.
- `w_valid` out 1; `w_data` out 64; `w_ready` in 1.
- `b_valid` in 1; `b_resp` in 2; `b_ready` out 1.

## Operation
- **Address:** `BASE_ADDR + {req_no, 3'b000}`, computed in ADDR_W bits and latched at acceptance. `req_no` = 255 gives 17'h107F8, which never wraps.
- **DRAM word packing:** [63:52] Index_A, [51:40] Index_B, [39:32] {4'b0, M}, [31:20] Index_C, [19:8] Index_D, [7:0] {3'b0, D}.
  - Write: pad bits are 0.
  - Read: pad bits are ignored; M = [35:32], D = [4:0].
- **States:** IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, latch `req_write`, address and `req_wdata`.
  - Go to RD_ADDR if read, WR_ADDR if write.
- **RD_ADDR:** `ar_valid` = 1 with a stable `ar_addr`; on `ar_ready`, go to RD_DATA.
- **RD_DATA:**
  - `r_ready` = 1.
  - On `r_valid`, register the unpacked data into `rsp_rdata` and set error = (`r_resp` != 0).
  - Go to DONE.
- **WR_ADDR:** `aw_valid` = 1; on `aw_ready`, go to WR_DATA. AW and W are never asserted together.
- **WR_DATA:** `w_valid` = 1 with the packed word; on `w_ready`, go to WR_RESP.
- **WR_RESP:** `b_ready` = 1; on `b_valid`, set error = (`b_resp` != 0) and go to DONE.
- **DONE:** `rsp_valid` = 1 for exactly one cycle, then IDLE.
- **Writes leave read data alone:** `rsp_rdata` keeps its previous value after a write.
- **Ignored inputs:** `r_valid`/`b_valid` arriving outside their state have no effect. Requests while `req_ready` = 0 are ignored and not queued.
- **Outputs:** all outputs are registered or decoded from the state register. No combinational path from any `*_ready`/`*_valid` input to any output.

## Timing
- **Reset:** any cycle with `rst` = 1 forces IDLE next edge. This includes mid-transaction; the outstanding AXI transaction is abandoned.
- **Reset values:**
  - `req_ready` = 1.
  - All `*_valid`, `*_ready` outputs = 0.
  - `rsp_valid` = 0, `rsp_err` = 0.
  - `rsp_rdata` = 0, `ar_addr` = `aw_addr` = 0, `w_data` = 0.
- **Handshake rule:** a handshake completes on a rising edge where valid and ready are both 1. Valid and payload hold until then.
- **Latency (zero-wait slave, ready already high):**
  - Read: accept at edge 0, `ar_valid` cycle 1, `r_ready` cycle 2, `rsp_valid` cycle 3.
  - Write: `aw_valid` cycle 1, `w_valid` cycle 2, `b_ready` cycle 3, `rsp_valid` cycle 4.
- **Back-to-back:** `req_ready` rises the cycle after `rsp_valid`. Minimum spacing between accepts is 4 cycles for reads and 5 for writes.
- **Slave stalls:** each cycle of ready/valid delay adds one cycle of latency. There is no timeout.

## Test plan
- **Read, zero wait:** reset, then read `req_no` = 8'h00 with `r_data` = 64'h123_456_0C_789_ABC_1F.
  - `ar_addr` = 17'h10000.
  - `rsp_rdata` = {12'h123, 12'h456, 12'h789, 12'hABC, 4'hC, 5'h1F}.
  - `rsp_valid` on cycle 3, `rsp_err` = 0.
- **Write, last entry:** write `req_no` = 8'hFF with `req_wdata` = {12'hFFF, 12'h001, 12'h800, 12'h7FF, 4'h1, 5'h01}.
  - `aw_addr` = 17'h107F8.
  - `w_data` = 64'hFFF_001_01_800_7FF_01.
  - `rsp_valid` on cycle 4, AW and W never overlapping.
- **Stalls:** `ar_ready` low 3 cycles and `r_valid` low 2 cycles. Require `ar_valid`/`ar_addr` stable throughout and `rsp_valid` on cycle 8.
- **Error response:** `b_resp` = 2'b10 on a write gives `rsp_err` = 1 with `rsp_valid`. A following read with `r_resp` = 0 gives `rsp_err` = 0.
- **Reset mid-read:** assert `rst` while in RD_DATA.
  - Next cycle: `req_ready` = 1, `r_ready` = 0, no `rsp_valid`.
  - A new read then completes normally.
- **Busy-time request plus spurious valid:** `req_valid` held during a busy write is not double-accepted and must yield exactly one `rsp_valid`. A spurious `b_valid` asserted during IDLE causes no state change.

Source files
------------

// File: rtl/dram_dir_bridge.sv
// dram_dir_bridge: single-outstanding AXI4-Lite-style master that reads or
// writes one Data_Dir record (57 bits) as a 64-bit pseudo-DRAM word.
// Latency: read 3 cycles, write 4 cycles from accept to rsp_valid (zero-wait slave).
// Backpressure: req_ready only in IDLE; every AXI channel waits on its ready/valid.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake; req_write, req_no, req_wdata
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion, unpacked read data, error
//   ar_*, r_*, aw_*, w_*, b_* : AXI4-Lite read/write channels toward the DRAM
module dram_dir_bridge #(
  parameter int               ADDR_W    = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_no,
  input  logic [56:0]       req_wdata,
  output logic              rsp_valid,
  output logic [56:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [63:0]       r_data,
  input  logic [1:0]        r_resp,
  output logic              r_ready,
  output logic              aw_valid,
  output logic [ADDR_W-1:0] aw_addr,
  input  logic              aw_ready,
  output logic              w_valid,
  output logic [63:0]       w_data,
  input  logic              w_ready,
  input  logic              b_valid,
  input  logic [1:0]        b_resp,
  output logic              b_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdat_q, wdat_d;
  logic [56:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  // Pad bits of the DRAM word carry no information on reads.
  logic unused_pad;
  assign unused_pad = ^{r_data[39:36], r_data[7:5]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_valid) state_d = req_write ? S_WR_ADDR : S_RD_ADDR;
      S_RD_ADDR: if (ar_ready)  state_d = S_RD_DATA;
      S_RD_DATA: if (r_valid)   state_d = S_DONE;
      S_WR_ADDR: if (aw_ready)  state_d = S_WR_DATA;
      S_WR_DATA: if (w_ready)   state_d = S_WR_RESP;
      S_WR_RESP: if (b_valid)   state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register, so no input
  // valid/ready ever reaches an output combinationally.
  always_comb begin
    req_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:    req_ready = 1'b1;
      S_RD_ADDR: ar_valid  = 1'b1;
      S_RD_DATA: r_ready   = 1'b1;
      S_WR_ADDR: aw_valid  = 1'b1;
      S_WR_DATA: w_valid   = 1'b1;
      S_WR_RESP: b_ready   = 1'b1;
      S_DONE:    rsp_valid = 1'b1;
      default:   req_ready = 1'b0;
    endcase
  end

  // Payload next-state: address and packed word are captured at accept so
  // they stay stable while the slave stalls.
  always_comb begin
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == S_IDLE && req_valid) begin
      addr_d = BASE_ADDR + ADDR_W'({req_no, 3'b000});
      if (req_write) begin
        // {Index_A, Index_B, 4'b0, M, Index_C, Index_D, 3'b0, D}
        wdat_d = {req_wdata[56:45], req_wdata[44:33], 4'b0000, req_wdata[8:5],
                  req_wdata[32:21], req_wdata[20:9], 3'b000, req_wdata[4:0]};
      end
    end
    if (state_q == S_RD_DATA && r_valid) begin
      // Back to {Index_A, Index_B, Index_C, Index_D, M, D}
      rdata_d = {r_data[63:52], r_data[51:40], r_data[31:20], r_data[19:8],
                 r_data[35:32], r_data[4:0]};
      err_d   = |r_resp;
    end
    if (state_q == S_WR_RESP && b_valid) begin
      err_d = |b_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // One address register serves both channels; only one is ever valid.
  assign ar_addr   = addr_q;
  assign aw_addr   = addr_q;
  assign w_data    = wdat_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dram_dir_bridge.sv
// Testbench for dram_dir_bridge: randomized requests against a reactive DRAM
// slave, with a record-level reference model feeding a response scoreboard.
module tb_dram_dir_bridge;

  localparam logic [16:0] BASE = 17'h10000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_no;
  logic [56:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [56:0] rsp_rdata;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [16:0] ar_addr, aw_addr;
  logic [63:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;

  dram_dir_bridge #(.ADDR_W(17), .BASE_ADDR(17'h10000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_no(req_no), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [56:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [16:0] addr_q[$];
  logic [63:0] wq[$];
  logic [63:0] mem [int];
  logic [56:0] model_rec [256];
  logic [56:0] last_rd;

  int checks = 0, failures = 0, cyc = 0, rsp_cnt = 0, issued = 0;
  int ar_stall = 0, r_stall = 0, aw_stall = 0, w_stall = 0, b_stall = 0;
  int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0, rd_a = 0, wr_a = 0;
  logic [1:0] cur_rresp = 2'b00, cur_bresp = 2'b00;
  logic spur_b = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_event required=event", nm);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Record <-> DRAM word, straight from the field map using shifts and masks.
  function automatic logic [63:0] pack(input logic [56:0] r);
    logic [63:0] x;
    x = 64'(r);
    return (((x >> 45) & 64'hFFF) << 52) | (((x >> 33) & 64'hFFF) << 40) |
           (((x >> 5) & 64'hF) << 32)    | (((x >> 21) & 64'hFFF) << 20) |
           (((x >> 9) & 64'hFFF) << 8)   | (x & 64'h1F);
  endfunction

  function automatic logic [56:0] unpack(input logic [63:0] w);
    logic [63:0] x;
    x = (((w >> 52) & 64'hFFF) << 45) | (((w >> 40) & 64'hFFF) << 33) |
        (((w >> 20) & 64'hFFF) << 21) | (((w >> 8) & 64'hFFF) << 9) |
        (((w >> 32) & 64'hF) << 5)    | (w & 64'h1F);
    return x[56:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reactive DRAM slave: each ready/valid rises after the programmed number
  // of stall cycles; it checks the address and write word at handshake.
  initial begin
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
    forever begin
      @(posedge clk); #1;
      if (ar_valid) begin
        ar_ready = (ar_c >= ar_stall);
        if (ar_ready) begin
          rd_a = int'(ar_addr);
          if (addr_q.size() == 0) chk("ar_unexpected", 64'(ar_addr), 64'h0);
          else chk("ar_addr", 64'(ar_addr), 64'(addr_q.pop_front()));
        end
        ar_c++;
      end else begin
        ar_ready = 0; ar_c = 0;
      end
      if (r_ready) begin
        r_valid = (r_c >= r_stall);
        r_data  = mem.exists(rd_a) ? mem[rd_a] : 64'h0;
        r_resp  = cur_rresp;
        r_c++;
      end else begin
        r_valid = 0; r_c = 0;
        r_data  = {$urandom, $urandom};
        r_resp  = 2'($urandom);
      end
      if (aw_valid) begin
        aw_ready = (aw_c >= aw_stall);
        if (aw_ready) begin
          wr_a = int'(aw_addr);
          if (addr_q.size() == 0) chk("aw_unexpected", 64'(aw_addr), 64'h0);
          else chk("aw_addr", 64'(aw_addr), 64'(addr_q.pop_front()));
        end
        aw_c++;
      end else begin
        aw_ready = 0; aw_c = 0;
      end
      if (w_valid) begin
        w_ready = (w_c >= w_stall);
        if (w_ready) begin
          if (wq.size() == 0) chk("w_unexpected", w_data, 64'h0);
          else chk("w_data", w_data, wq.pop_front());
          mem[wr_a] = w_data;
        end
        w_c++;
      end else begin
        w_ready = 0; w_c = 0;
      end
      if (b_ready) begin
        b_valid = (b_c >= b_stall);
        b_resp  = b_valid ? cur_bresp : 2'($urandom);
        b_c++;
      end else begin
        b_valid = spur_b; b_c = 0;
        b_resp  = 2'($urandom);
      end
    end
  end

  // Monitor: response scoreboard plus channel protocol checks.
  logic        p_arv = 0, p_arr = 0, p_rst = 1;
  logic [16:0] p_ara = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (aw_valid || w_valid) chk("aw_w_overlap", 64'(aw_valid && w_valid), 64'h0);
      if (p_arv && !p_arr && !p_rst) begin
        chk("ar_valid_hold", 64'(ar_valid), 64'h1);
        chk("ar_addr_hold", 64'(ar_addr), 64'(p_ara));
      end
      p_arv = ar_valid; p_arr = ar_ready; p_ara = ar_addr; p_rst = rst;
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=rsp_valid required=idle");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [7:0] no, input logic [56:0] wd,
                        input int s_ar, input int s_r, input int s_aw, input int s_w,
                        input int s_b, input logic [1:0] rr, input logic [1:0] br,
                        input bit hold, input bit wt);
    exp_t e;
    int n;
    n = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) timeout("req_ready");
    end
    ar_stall = s_ar; r_stall = s_r; aw_stall = s_aw; w_stall = s_w; b_stall = s_b;
    cur_rresp = rr; cur_bresp = br;
    req_valid = 1; req_write = wr; req_no = no; req_wdata = wd;
    addr_q.push_back(17'(int'(BASE) + int'(no) * 8));
    if (wr) begin
      wq.push_back(pack(wd));
      e.rdata = last_rd;
      e.err   = (br != 2'b00);
      e.lat   = 4 + s_aw + s_w + s_b;
      model_rec[no] = wd;
    end else begin
      e.rdata = model_rec[no];
      last_rd = model_rec[no];
      e.err   = (rr != 2'b00);
      e.lat   = 3 + s_ar + s_r;
    end
    @(posedge clk); #1;
    e.acc = cyc;
    exp_q.push_back(e);
    issued++;
    if (hold) begin
      // Keep the strobe up with different payloads while the bridge is busy.
      repeat (3) begin
        req_no = 8'($urandom); req_write = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    req_valid = 0; req_no = 8'($urandom);
    req_wdata = {25'($urandom), $urandom};
    if (wt) begin
      n = 0;
      while (exp_q.size() != 0) begin
        @(posedge clk); #1;
        n++;
        if (n > 300) timeout("rsp_valid");
      end
    end
  endtask

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [63:0] w;
    logic [56:0] rec, rec2;
    logic        rwr;
    logic [7:0]  rno;
    logic [1:0]  rresp, bresp;
    int          n;
    rst = 1; req_valid = 0; req_write = 0; req_no = 0; req_wdata = 0;
    last_rd = '0;
    for (int i = 0; i < 256; i++) begin
      w = {$urandom, $urandom};
      mem[int'(BASE) + i * 8] = w;
      model_rec[i] = unpack(w);
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset values
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_ar_valid", 64'(ar_valid), 64'h0);
    chk("rst_r_ready", 64'(r_ready), 64'h0);
    chk("rst_aw_valid", 64'(aw_valid), 64'h0);
    chk("rst_w_valid", 64'(w_valid), 64'h0);
    chk("rst_b_ready", 64'(b_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_ar_addr", 64'(ar_addr), 64'h0);
    chk("rst_aw_addr", 64'(aw_addr), 64'h0);
    chk("rst_w_data", w_data, 64'h0);

    // Read entry 0, zero wait
    w = 64'h123_456_0C_789_ABC_1F;
    mem[int'(BASE)] = w;
    model_rec[0] = unpack(w);
    do_req(0, 8'h00, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    rec = {12'h123, 12'h456, 12'h789, 12'hABC, 4'hC, 5'h1F};
    chk("t_read0_rdata", 64'(rsp_rdata), 64'(rec));

    // Write the last entry, zero wait
    rec2 = {12'hFFF, 12'h001, 12'h800, 12'h7FF, 4'h1, 5'h01};
    do_req(1, 8'hFF, rec2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    chk("t_wr255_aw_addr", 64'(aw_addr), 64'h107F8);
    chk("t_wr255_w_data", w_data, 64'hFFF_001_01_800_7FF_01);
    chk("t_wr255_rdata_kept", 64'(rsp_rdata), 64'(rec));

    // Read back the entry just written, then a stalled read
    do_req(0, 8'hFF, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    do_req(0, 8'h21, '0, 3, 2, 0, 0, 0, 2'b00, 2'b00, 0, 1);

    // Error response on write, clean read afterwards
    do_req(1, 8'h05, {25'($urandom), $urandom}, 0, 0, 1, 2, 1, 2'b00, 2'b10, 0, 1);
    do_req(0, 8'h05, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);

    // Reset while waiting for read data
    do_req(0, 8'h10, '0, 0, 6, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n = 0;
    while (!r_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) timeout("r_ready");
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_req_ready", 64'(req_ready), 64'h1);
    chk("rst_mid_r_ready", 64'(r_ready), 64'h0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_mid_rsp_rdata", 64'(rsp_rdata), 64'h0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    issued--;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    do_req(0, 8'h10, '0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1);

    // Request held high while a write is in flight
    do_req(1, 8'h33, {25'($urandom), $urandom}, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    repeat (4) @(posedge clk);
    #1;

    // Spurious b_valid while idle
    spur_b = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("spur_b_req_ready", 64'(req_ready), 64'h1);
      chk("spur_b_b_ready", 64'(b_ready), 64'h0);
    end
    spur_b = 0;

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      rwr   = 1'($urandom_range(0, 1));
      rno   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_req(rwr, rno, {25'($urandom), $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), rresp, bresp, 0, 1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_rsp_count", 64'(rsp_cnt), 64'(issued));
    chk("final_addr_q_empty", 64'(addr_q.size()), 64'h0);
    chk("final_wq_empty", 64'(wq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
